// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad path: scanner code width, key-code map
// and the state encodings used by the entry front end.
package keypad_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] KEY_PLUS = 5'd10;
  localparam logic [CODE_W-1:0] KEY_EQ   = 5'd11;
  localparam logic [CODE_W-1:0] KEY_CLR  = 5'd12;
  localparam logic [CODE_W-1:0] KEY_BS   = 5'd13;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ISSUE   = 2'd2
  } entry_state_t;

  typedef enum logic {
    DB_ARMED  = 1'b0,
    DB_LOCKED = 1'b1
  } db_state_t;

  function automatic logic is_digit_code(input logic [CODE_W-1:0] code);
    return (code <= 5'd9);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Turns the raw scanner strobe into one press pulse per physical key press:
// counts matching hits while armed, then locks until a long enough release.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int PRESS_HITS     = 4,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_flag,
  input  logic [CODE_W-1:0] key_code,
  output logic              press,
  output logic [CODE_W-1:0] press_code
);

  localparam logic [3:0] HITS_C    = 4'(PRESS_HITS);
  localparam logic [8:0] REL_C     = 9'(RELEASE_CYCLES);
  localparam logic [7:0] REL_SAT_C = 8'(RELEASE_CYCLES);

  db_state_t         db_state_r, db_state_nxt_s;
  logic [CODE_W-1:0] code_r, code_nxt_s;
  logic [3:0]        hits_r, hits_nxt_s, hits_inc_s;
  logic [7:0]        low_cnt_r, low_cnt_nxt_s;
  logic [8:0]        low_inc_s;
  logic              press_r, press_nxt_s;
  logic              release_s;

  // a different code (or an empty counter) restarts the hit count at one
  always_comb begin
    if (hits_r != 4'd0 && code_r == key_code) begin
      hits_inc_s = hits_r + 4'd1;
    end else begin
      hits_inc_s = 4'd1;
    end
    low_inc_s = {1'b0, low_cnt_r} + 9'd1;
    release_s = (low_inc_s >= REL_C);
  end

  // hit/release counting and ARMED/LOCKED transitions
  always_comb begin
    db_state_nxt_s = db_state_r;
    code_nxt_s     = code_r;
    hits_nxt_s     = hits_r;
    low_cnt_nxt_s  = low_cnt_r;
    press_nxt_s    = 1'b0;
    if (key_flag) begin
      low_cnt_nxt_s = 8'd0;
      if (db_state_r == DB_ARMED) begin
        code_nxt_s = key_code;
        if (hits_inc_s == HITS_C) begin
          press_nxt_s    = 1'b1;
          hits_nxt_s     = 4'd0;
          db_state_nxt_s = DB_LOCKED;
        end else begin
          hits_nxt_s = hits_inc_s;
        end
      end else begin
        hits_nxt_s = 4'd0;
      end
    end else if (release_s) begin
      low_cnt_nxt_s  = REL_SAT_C;
      hits_nxt_s     = 4'd0;
      db_state_nxt_s = DB_ARMED;
    end else begin
      low_cnt_nxt_s = low_inc_s[7:0];
    end
  end

  // debouncer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state_r <= DB_ARMED;
      code_r     <= 5'd0;
      hits_r     <= 4'd0;
      low_cnt_r  <= 8'd0;
      press_r    <= 1'b0;
    end else begin
      db_state_r <= db_state_nxt_s;
      code_r     <= code_nxt_s;
      hits_r     <= hits_nxt_s;
      low_cnt_r  <= low_cnt_nxt_s;
      press_r    <= press_nxt_s;
    end
  end

  assign press      = press_r;
  assign press_code = code_r;

endmodule

// File: rtl/key_entry.sv
// Keypad front end: debounced key events edit two decimal operands, which are
// then offered to the adder as a pair over a valid/ready handshake.
module key_entry
  import keypad_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESS_HITS     = 4,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_flag,
  input  logic [4:0]       key_code,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] disp_val,
  output logic [1:0]       entry_state,
  output logic             key_err
);

  logic              press_s;
  logic [CODE_W-1:0] press_code_s;

  key_debounce #(
    .PRESS_HITS     (PRESS_HITS),
    .RELEASE_CYCLES (RELEASE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_flag   (key_flag),
    .key_code   (key_code),
    .press      (press_s),
    .press_code (press_code_s)
  );

  entry_state_t     state_r, state_nxt_s;
  logic [WIDTH-1:0] acc_a_r, acc_b_r, op_a_r, op_b_r, disp_r;
  logic [WIDTH-1:0] acc_a_nxt_s, acc_b_nxt_s, op_a_nxt_s, op_b_nxt_s, disp_nxt_s;
  logic             op_valid_r, op_valid_nxt_s, key_err_r, key_err_nxt_s;
  logic             is_digit_s, is_plus_s, is_eq_s, is_clr_s, is_bs_s;
  logic [WIDTH-1:0] edit_acc_s, bs_val_s;
  logic [WIDTH+3:0] digit_sum_s;
  logic             digit_ovf_s;

  // key classification; events during ISSUE are dropped here
  always_comb begin
    is_digit_s = 1'b0;
    is_plus_s  = 1'b0;
    is_eq_s    = 1'b0;
    is_clr_s   = 1'b0;
    is_bs_s    = 1'b0;
    if (press_s && state_r != ISSUE) begin
      if (is_digit_code(press_code_s)) begin
        is_digit_s = 1'b1;
      end else begin
        case (press_code_s)
          KEY_PLUS: is_plus_s = 1'b1;
          KEY_EQ:   is_eq_s   = 1'b1;
          KEY_CLR:  is_clr_s  = 1'b1;
          KEY_BS:   is_bs_s   = 1'b1;
          default:  is_plus_s = 1'b0;
        endcase
      end
    end else begin
      is_digit_s = 1'b0;
    end
  end

  // acc*10 + d is formed 4 bits wider so overflow is detectable
  always_comb begin
    if (state_r == ENTER_B) begin
      edit_acc_s = acc_b_r;
    end else begin
      edit_acc_s = acc_a_r;
    end
    digit_sum_s = ({4'd0, edit_acc_s} << 3) + ({4'd0, edit_acc_s} << 1)
                + {{WIDTH{1'b0}}, press_code_s[3:0]};
    digit_ovf_s = |digit_sum_s[WIDTH+3:WIDTH];
    bs_val_s    = edit_acc_s / WIDTH'(10);
  end

  // entry FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ENTER_A: begin
        if (is_plus_s) begin
          state_nxt_s = ENTER_B;
        end else begin
          state_nxt_s = ENTER_A;
        end
      end
      ENTER_B: begin
        if (is_clr_s) begin
          state_nxt_s = ENTER_A;
        end else if (is_eq_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = ENTER_B;
        end
      end
      ISSUE: begin
        if (op_ready) begin
          state_nxt_s = ENTER_A;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      default: state_nxt_s = ENTER_A;
    endcase
  end

  // entry FSM datapath and output values
  always_comb begin
    acc_a_nxt_s    = acc_a_r;
    acc_b_nxt_s    = acc_b_r;
    op_a_nxt_s     = op_a_r;
    op_b_nxt_s     = op_b_r;
    op_valid_nxt_s = op_valid_r;
    key_err_nxt_s  = 1'b0;
    case (state_r)
      ENTER_A, ENTER_B: begin
        if (is_digit_s) begin
          if (digit_ovf_s) begin
            key_err_nxt_s = 1'b1;
          end else if (state_r == ENTER_A) begin
            acc_a_nxt_s = digit_sum_s[WIDTH-1:0];
          end else begin
            acc_b_nxt_s = digit_sum_s[WIDTH-1:0];
          end
        end else if (is_bs_s) begin
          if (state_r == ENTER_A) begin
            acc_a_nxt_s = bs_val_s;
          end else begin
            acc_b_nxt_s = bs_val_s;
          end
        end else if (is_clr_s) begin
          acc_a_nxt_s = {WIDTH{1'b0}};
          acc_b_nxt_s = {WIDTH{1'b0}};
          op_a_nxt_s  = {WIDTH{1'b0}};
          op_b_nxt_s  = {WIDTH{1'b0}};
        end else if (is_plus_s) begin
          if (state_r == ENTER_A) begin
            op_a_nxt_s = acc_a_r;
          end else begin
            key_err_nxt_s = 1'b1;
          end
        end else if (is_eq_s) begin
          if (state_r == ENTER_B) begin
            op_b_nxt_s     = acc_b_r;
            op_valid_nxt_s = 1'b1;
          end else begin
            key_err_nxt_s = 1'b1;
          end
        end else begin
          key_err_nxt_s = 1'b0;
        end
      end
      ISSUE: begin
        if (op_ready) begin
          op_valid_nxt_s = 1'b0;
          acc_a_nxt_s    = {WIDTH{1'b0}};
          acc_b_nxt_s    = {WIDTH{1'b0}};
        end else begin
          op_valid_nxt_s = 1'b1;
        end
      end
      default: op_valid_nxt_s = 1'b0;
    endcase

    case (state_nxt_s)
      ENTER_A: disp_nxt_s = acc_a_nxt_s;
      ENTER_B: disp_nxt_s = acc_b_nxt_s;
      ISSUE:   disp_nxt_s = op_b_nxt_s;
      default: disp_nxt_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ENTER_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // operand, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a_r    <= {WIDTH{1'b0}};
      acc_b_r    <= {WIDTH{1'b0}};
      op_a_r     <= {WIDTH{1'b0}};
      op_b_r     <= {WIDTH{1'b0}};
      disp_r     <= {WIDTH{1'b0}};
      op_valid_r <= 1'b0;
      key_err_r  <= 1'b0;
    end else begin
      acc_a_r    <= acc_a_nxt_s;
      acc_b_r    <= acc_b_nxt_s;
      op_a_r     <= op_a_nxt_s;
      op_b_r     <= op_b_nxt_s;
      disp_r     <= disp_nxt_s;
      op_valid_r <= op_valid_nxt_s;
      key_err_r  <= key_err_nxt_s;
    end
  end

  assign op_a        = op_a_r;
  assign op_b        = op_b_r;
  assign op_valid    = op_valid_r;
  assign disp_val    = disp_r;
  assign entry_state = state_r;
  assign key_err     = key_err_r;

endmodule

// File: tb/tb_key_entry.sv
// Directed bench for key_entry: key presses from a vector table plus
// hand-written scanner, glitch, handshake and reset sequences.
module tb_key_entry;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_flag = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       op_ready = 1'b0;
  logic [7:0] op_a, op_b, disp_val;
  logic       op_valid, key_err;
  logic [1:0] entry_state;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  key_entry #(.WIDTH(8), .PRESS_HITS(4), .RELEASE_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag    (key_flag),
    .key_code    (key_code),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .disp_val    (disp_val),
    .entry_state (entry_state),
    .key_err     (key_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] code;
    logic [7:0] disp;
    logic [1:0] st;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       valid;
    logic       err;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic [4:0] c);
    key_flag = f;
    key_code = c;
    @(posedge clk);
    #1;
    if (key_err) err_pulses++;
  endtask

  task automatic press_key(input logic [4:0] c);
    for (int i = 0; i < 4; i++) cyc(1'b1, c);
    for (int i = 0; i < 10; i++) cyc(1'b0, c);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      err_pulses = 0;
      press_key(tbl[i].code);
      chk($sformatf("row%0d disp", i), disp_val, tbl[i].disp);
      chk($sformatf("row%0d state", i), entry_state, tbl[i].st);
      chk($sformatf("row%0d op_a", i), op_a, tbl[i].opa);
      chk($sformatf("row%0d op_b", i), op_b, tbl[i].opb);
      chk($sformatf("row%0d op_valid", i), op_valid, tbl[i].valid);
      chk($sformatf("row%0d key_err", i), err_pulses, tbl[i].err);
    end
  endtask

  initial begin
    //            code      disp    st    opa     opb    v     err
    tbl[0]  = '{5'd1,     8'd1,   2'd0, 8'd0,  8'd0,  1'b0, 1'b0};
    tbl[1]  = '{5'd2,     8'd12,  2'd0, 8'd0,  8'd0,  1'b0, 1'b0};
    tbl[2]  = '{KEY_PLUS, 8'd0,   2'd1, 8'd12, 8'd0,  1'b0, 1'b0};
    tbl[3]  = '{5'd3,     8'd3,   2'd1, 8'd12, 8'd0,  1'b0, 1'b0};
    tbl[4]  = '{5'd4,     8'd34,  2'd1, 8'd12, 8'd0,  1'b0, 1'b0};
    tbl[5]  = '{KEY_EQ,   8'd34,  2'd2, 8'd12, 8'd34, 1'b1, 1'b0};
    tbl[6]  = '{KEY_CLR,  8'd34,  2'd2, 8'd12, 8'd34, 1'b1, 1'b0};
    tbl[7]  = '{5'd2,     8'd2,   2'd0, 8'd12, 8'd34, 1'b0, 1'b0};
    tbl[8]  = '{5'd5,     8'd25,  2'd0, 8'd12, 8'd34, 1'b0, 1'b0};
    tbl[9]  = '{5'd5,     8'd255, 2'd0, 8'd12, 8'd34, 1'b0, 1'b0};
    tbl[10] = '{5'd1,     8'd255, 2'd0, 8'd12, 8'd34, 1'b0, 1'b1};
    tbl[11] = '{KEY_BS,   8'd25,  2'd0, 8'd12, 8'd34, 1'b0, 1'b0};
    tbl[12] = '{5'd14,    8'd25,  2'd0, 8'd12, 8'd34, 1'b0, 1'b0};
    tbl[13] = '{KEY_EQ,   8'd25,  2'd0, 8'd12, 8'd34, 1'b0, 1'b1};
    tbl[14] = '{KEY_PLUS, 8'd0,   2'd1, 8'd25, 8'd34, 1'b0, 1'b0};
    tbl[15] = '{KEY_PLUS, 8'd0,   2'd1, 8'd25, 8'd34, 1'b0, 1'b1};
    tbl[16] = '{5'd9,     8'd9,   2'd1, 8'd25, 8'd34, 1'b0, 1'b0};
    tbl[17] = '{KEY_CLR,  8'd0,   2'd0, 8'd0,  8'd0,  1'b0, 1'b0};
    tbl[18] = '{KEY_BS,   8'd0,   2'd0, 8'd0,  8'd0,  1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset op_a", op_a, 0);
    chk("reset op_b", op_b, 0);
    chk("reset op_valid", op_valid, 0);
    chk("reset disp", disp_val, 0);
    chk("reset state", entry_state, 0);
    chk("reset key_err", key_err, 0);
    rst_n = 1'b1;

    // scanner-like strobe: one hit every 4 cycles must yield exactly one event
    for (int i = 0; i < 40; i++) cyc((i % 4) == 0, 5'd7);
    for (int i = 0; i < 10; i++) cyc(1'b0, 5'd7);
    chk("scan single event", disp_val, 7);
    press_key(5'd3);
    chk("second digit", disp_val, 73);
    press_key(KEY_CLR);
    chk("clear in A", disp_val, 0);

    // two hits then a full release: counter must forget those hits
    for (int i = 0; i < 2; i++) cyc(1'b1, 5'd5);
    for (int i = 0; i < 9; i++) cyc(1'b0, 5'd5);
    chk("glitch no event", disp_val, 0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 5'd5);
    for (int i = 0; i < 10; i++) cyc(1'b0, 5'd5);
    chk("glitch hits cleared", disp_val, 0);

    // code switch restarts the count on the new code
    for (int i = 0; i < 2; i++) cyc(1'b1, 5'd4);
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd6);
    for (int i = 0; i < 10; i++) cyc(1'b0, 5'd6);
    chk("code switch", disp_val, 6);
    press_key(KEY_CLR);
    chk("clear again", disp_val, 0);

    run_rows(0, 6);

    // pair held stable while the adder stalls
    op_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 5'd0);
      chk($sformatf("hold%0d op_valid", i), op_valid, 1);
      chk($sformatf("hold%0d op_a", i), op_a, 12);
      chk($sformatf("hold%0d op_b", i), op_b, 34);
    end
    op_ready = 1'b1;
    cyc(1'b0, 5'd0);
    op_ready = 1'b0;
    chk("xfer op_valid", op_valid, 0);
    chk("xfer state", entry_state, 0);
    chk("xfer disp", disp_val, 0);
    chk("xfer op_a kept", op_a, 12);
    chk("xfer op_b kept", op_b, 34);

    run_rows(7, 18);

    // asynchronous reset while a pair is pending
    press_key(5'd1);
    press_key(KEY_PLUS);
    press_key(5'd2);
    press_key(KEY_EQ);
    chk("pre-reset op_valid", op_valid, 1);
    chk("pre-reset op_b", op_b, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async op_valid", op_valid, 0);
    chk("async op_a", op_a, 0);
    chk("async op_b", op_b, 0);
    chk("async disp", disp_val, 0);
    chk("async state", entry_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    err_pulses = 0;
    press_key(5'd8);
    chk("post-reset digit", disp_val, 8);
    chk("post-reset state", entry_state, 0);
    chk("post-reset key_err", err_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- Downstream consumer of the 4x4 keypad scanner; takes its raw `key_code`/`key_flag` stream.
- Debounces the stream into single key-press events and accumulates decimal digits into two operands.
- Hands the operand pair to the serial adder over a valid/ready handshake.
- Sole path between keypad and arithmetic datapath.

Parameters:
- WIDTH, 8, operand width in bits.
- PRESS_HITS, 4, flag-high cycles with identical code required to accept a press (range 1..15).
- RELEASE_CYCLES, 8, consecutive flag-low cycles that count as release. Must be ≥ 2x the scanner line-rotation period of 4; range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_flag  in  1  scanner "key seen this cycle" strobe.
- key_code  in  5  scanner key code, valid when key_flag=1.
- op_a  out  WIDTH  committed operand A.
- op_b  out  WIDTH  committed operand B.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  adder accepts pair.
- disp_val  out  WIDTH  accumulator currently being edited, for display.
- entry_state  out  2  0=ENTER_A, 1=ENTER_B, 2=ISSUE.
- key_err  out  1  one-cycle pulse on rejected key.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=ENTER_A, accumulators 0, debouncer idle/armed. Reset mid-handshake drops the pair; op_valid falls asynchronously.
- Debouncer states:
  - ARMED: first cycle with key_flag=1 captures key_code, hit count=1.
  - Each later key_flag=1 cycle: same code increments hits; a different code recaptures it with hits=1.
  - key_flag=0 cycles do not reset hits; RELEASE_CYCLES consecutive low cycles clear hits.
  - hits reaching PRESS_HITS: one-cycle press event for the captured code, then LOCKED.
  - LOCKED: no further events until RELEASE_CYCLES consecutive key_flag=0 cycles, then ARMED.
  - Event occurs on the clock edge where hits reaches PRESS_HITS; effect visible on outputs the next cycle.
- Key map (press events):
  - 0..9: digit.
  - 10: '+'.
  - 11: '='.
  - 12: clear.
  - 13: backspace.
  - 14..31: ignored, no key_err.
- Digit: new = acc*10 + d, computed at WIDTH+4 bits. If new > 2^WIDTH-1, accumulator unchanged and key_err pulses; else acc=new.
- Backspace: acc = acc/10 (integer divide); acc=0 stays 0.
- Clear (ENTER_A/ENTER_B): both accumulators 0, op_a/op_b 0, FSM → ENTER_A.
- FSM transitions:
  - ENTER_A, '+': op_a=accA → ENTER_B.
  - ENTER_A, '=': key_err, no transition.
  - ENTER_B, '=': op_b=accB, op_valid=1 → ISSUE.
  - ENTER_B, '+': key_err, no transition.
  - ISSUE: op_a/op_b/op_valid held stable while op_valid=1 and op_ready=0.
  - ISSUE, op_ready=1: transfer; next cycle op_valid=0, accumulators 0, → ENTER_A. op_a/op_b keep their last values until the next commit.
  - ISSUE, any press event: dropped silently (no key_err). This includes clear; there is no abort of a pending pair.
- disp_val: ENTER_A shows accA, ENTER_B shows accB, ISSUE shows op_b.
- key_err and press event are never asserted in the same cycle for different keys; at most one event per cycle.

Decomposition:
- Shared package `keypad_pkg`:
  - Key-code constants: KEY_PLUS=10, KEY_EQ=11, KEY_CLR=12, KEY_BS=13.
  - Typedef `entry_state_t` (2-bit enum ENTER_A/ENTER_B/ISSUE).
  - Scanner code width 5.
- Sub-module `key_debounce`: hit/release counters and the ARMED/LOCKED machine. Outputs `press` pulse and `press_code[4:0]`.
- Top `key_entry`: accumulator arithmetic, FSM and handshake.

Test Plan:
- key_flag=1, code=7 held; pattern 1,0,0,0 repeating (scanner-like) for 40 cycles, then low 10 cycles → exactly one digit event; disp_val=7. Second press of 3 → disp_val=73.
- Glitch: code=5 for 2 hits, then low 9 cycles → no event, disp_val unchanged. Code switch 4→6 mid-count → event with code 6 after 4 hits of 6.
- Sequence 1,2,'+',3,4,'=' with op_ready=0 for 5 cycles → op_a=12, op_b=34, op_valid stable 5 cycles; op_ready=1 → op_valid=0 next cycle, entry_state=0.
- WIDTH=8: digits 2,5,5 → 255; digit 1 → key_err pulse, disp_val=255; backspace → 25.
- '=' in ENTER_A → key_err, state 0. Clear in ENTER_B with accB=9 → state 0, disp_val=0, op_a=0.
- Assert rst_n=0 while op_valid=1 → op_valid, op_a, op_b, disp_val all 0 immediately. After release, first press accepted normally.
